// File: rtl/exu_alu_arbiter.sv
// exu_alu_arbiter: shares one combinational EXU ALU between two requesters,
// with a one-entry registered response buffer per requester (one-cycle latency).
module exu_alu_arbiter #(
  parameter int XLEN  = 32,
  parameter int SEL_W = 11,
  parameter bit RR    = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  // requester 0 (integer pipeline)
  input  logic             r0_req_valid,
  output logic             r0_req_ready,
  input  logic [XLEN-1:0]  r0_req_a,
  input  logic [XLEN-1:0]  r0_req_b,
  input  logic [SEL_W-1:0] r0_req_sel,
  output logic             r0_rsp_valid,
  input  logic             r0_rsp_ready,
  output logic [XLEN-1:0]  r0_rsp_data,
  output logic             r0_rsp_err,
  // requester 1 (address/aux unit)
  input  logic             r1_req_valid,
  output logic             r1_req_ready,
  input  logic [XLEN-1:0]  r1_req_a,
  input  logic [XLEN-1:0]  r1_req_b,
  input  logic [SEL_W-1:0] r1_req_sel,
  output logic             r1_rsp_valid,
  input  logic             r1_rsp_ready,
  output logic [XLEN-1:0]  r1_rsp_data,
  output logic             r1_rsp_err,
  // shared ALU
  output logic [XLEN-1:0]  alu_a,
  output logic [XLEN-1:0]  alu_b,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [XLEN-1:0]  alu_out
);

  localparam int NREQ = 2;

  typedef struct packed {
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic [SEL_W-1:0] sel;
  } req_t;

  req_t            req [NREQ];
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] rsp_ready;
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] cand;
  logic [NREQ-1:0] grant;

  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [NREQ-1:0] rsp_err_q,   rsp_err_d;
  logic [XLEN-1:0] rsp_data_q [NREQ];
  logic [XLEN-1:0] rsp_data_d [NREQ];
  logic            last_grant_q, last_grant_d;

  assign req[0]    = '{a: r0_req_a, b: r0_req_b, sel: r0_req_sel};
  assign req[1]    = '{a: r1_req_a, b: r1_req_b, sel: r1_req_sel};
  assign req_valid = {r1_req_valid, r0_req_valid};
  assign rsp_ready = {r1_rsp_ready, r0_rsp_ready};

  // A select is legal only when exactly one bit is set.
  function automatic logic sel_illegal(input logic [SEL_W-1:0] sel);
    return (sel == '0) || ((sel & (sel - SEL_W'(1))) != '0);
  endfunction

  // Arbitration: a full buffer that drains this cycle can take a new result.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    elig  = ~rsp_valid_q | rsp_ready;
    cand  = req_valid & elig;
    grant = '0;
    if (rst_n) begin
      case (cand)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = (RR && !last_grant_q) ? 2'b10 : 2'b01;
        default: grant = '0;
      endcase
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (grant[1])      last_grant_d = 1'b1;
    else if (grant[0]) last_grant_d = 1'b0;
  end

  // Drive the ALU from the granted request only; hold it at zero when idle.
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant[k]) begin
        alu_a   = req[k].a;
        alu_b   = req[k].b;
        alu_sel = req[k].sel;
      end
    end
  end

  // Response buffers: capture wins over drain, so drain+capture keeps valid high.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_data_d  = rsp_data_q;
    for (int k = 0; k < NREQ; k++) begin
      if (grant[k]) begin
        rsp_valid_d[k] = 1'b1;
        rsp_data_d[k]  = alu_out;
        rsp_err_d[k]   = sel_illegal(req[k].sel);
      end else if (rsp_ready[k]) begin
        rsp_valid_d[k] = 1'b0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q  <= '0;
      rsp_err_q    <= '0;
      last_grant_q <= 1'b1;
      // NOTE: the result buffers are reset too, because their value is architecturally visible.
      for (int k = 0; k < NREQ; k++) rsp_data_q[k] <= '0;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      last_grant_q <= last_grant_d;
      for (int k = 0; k < NREQ; k++) rsp_data_q[k] <= rsp_data_d[k];
    end
  end

  assign r0_req_ready = grant[0];
  assign r1_req_ready = grant[1];
  assign r0_rsp_valid = rsp_valid_q[0];
  assign r1_rsp_valid = rsp_valid_q[1];
  assign r0_rsp_data  = rsp_data_q[0];
  assign r1_rsp_data  = rsp_data_q[1];
  assign r0_rsp_err   = rsp_err_q[0];
  assign r1_rsp_err   = rsp_err_q[1];

  a_single_grant : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));

endmodule
